// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and parity modes.
// Used by the receiver and intended for reuse by the matching transmitter.
package uart_pkg;

    // 100 MHz system clock at 115200 baud
    localparam int DEFAULT_CLK_PER_BIT = 868;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_RECOVER = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = S_IDLE,
        START   = S_START,
        DATA    = S_DATA,
        PARITY  = S_PARITY,
        STOP    = S_STOP,
        RECOVER = S_RECOVER
    } state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Parity bit a transmitter would send for this data word.
    function automatic logic expected_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Double-flop synchroniser for asynchronous single-bit inputs.
// Resets to 1 so an idle-high line does not look active during reset release.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 5..8 data bits LSB-first, 1 or 2 stop bits.
// Define UART_RX_PARITY_EN to add a parity bit check (PARITY_ODD selects odd/even).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = PAR_EVEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       dout_vld,
    output logic [7:0] dout_data,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int             CW        = $clog2(CLK_PER_BIT);
    localparam int             HALF      = CLK_PER_BIT / 2;
    localparam logic [CW-1:0]  HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic           ODD_MODE  = (PARITY_ODD == PAR_ODD);

    logic          din_s;
    logic          bit_end;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    idx_reg, idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          ferr_reg, ferr_next;
    logic          vld_reg, vld_next;
    logic [7:0]    data_reg, data_next;
    logic          fout_reg, fout_next;
`ifdef UART_RX_PARITY_EN
    logic          perr_reg, perr_next;
    logic          pout_reg, pout_next;
`endif

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (din_s)
    );

    assign bit_end = (cnt_reg == BIT_LAST);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        ferr_next  = ferr_reg;
        vld_next   = 1'b0;
        data_next  = data_reg;
        fout_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_next  = perr_reg;
        pout_next  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (!din_s) begin
                    state_next = START;
                    cnt_next   = '0;
                    shift_next = '0;
                    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_next  = 1'b0;
`endif
                end
            end
            START: begin
                // Line must stay low until the middle of the start bit.
                if (din_s) begin
                    state_next = IDLE;
                end else if (cnt_reg == HALF_LAST) begin
                    state_next = DATA;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next            = '0;
                    shift_next[idx_reg] = shift_reg[idx_reg] | din_s;
                    if (idx_reg == DATA_LAST) begin
                        idx_next   = '0;
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    perr_next  = (din_s != expected_parity(shift_reg, ODD_MODE));
                    state_next = STOP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (idx_reg == STOP_LAST) begin
                        vld_next   = 1'b1;
                        data_next  = shift_reg;
                        fout_next  = ferr_reg | ~din_s;
`ifdef UART_RX_PARITY_EN
                        pout_next  = perr_reg;
`endif
                        idx_next   = '0;
                        state_next = (ferr_reg | ~din_s) ? RECOVER : IDLE;
                    end else begin
                        ferr_next = ferr_reg | ~din_s;
                        idx_next  = idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RECOVER: begin
                // Hold off a held-low (break) line from looking like new start bits.
                if (din_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            ferr_reg  <= 1'b0;
            vld_reg   <= 1'b0;
            data_reg  <= '0;
            fout_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_reg  <= 1'b0;
            pout_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            ferr_reg  <= ferr_next;
            vld_reg   <= vld_next;
            data_reg  <= data_next;
            fout_reg  <= fout_next;
`ifdef UART_RX_PARITY_EN
            perr_reg  <= perr_next;
            pout_reg  <= pout_next;
`endif
        end
    end

    assign dout_vld  = vld_reg;
    assign dout_data = data_reg;
    assign frame_err = fout_reg;
    assign busy      = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = pout_reg;
`else
    // PARITY_ODD has no effect without the checker.
    assign parity_err = 1'b0 & ODD_MODE;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: an 8-data/1-stop and a 7-data/2-stop instance.
// Frames gain a parity bit when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_param;
    import uart_pkg::*;

`ifdef UART_RX_PARITY_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic line = 1'b1;
    int   cur_sel = 0;
    logic din8, din7;

    logic       vld8, fe8, pe8, busy8;
    logic [7:0] data8;
    logic       vld7, fe7, pe7, busy7;
    logic [7:0] data7;

    assign din8 = (cur_sel == 0) ? line : 1'b1;
    assign din7 = (cur_sel == 1) ? line : 1'b1;

    uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PAR_EVEN)) dut8 (
        .clk(clk), .rst(rst), .din(din8), .dout_vld(vld8), .dout_data(data8),
        .frame_err(fe8), .parity_err(pe8), .busy(busy8)
    );

    uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(PAR_EVEN)) dut7 (
        .clk(clk), .rst(rst), .din(din7), .dout_vld(vld7), .dout_data(data7),
        .frame_err(fe7), .parity_err(pe7), .busy(busy7)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output pulse of both instances
    int         n_vld [2];
    logic [7:0] cap_data [2];
    logic [7:0] cap_data_prev [2];
    logic       cap_fe [2];
    logic       cap_pe [2];
    int         cap_t [2];
    int         cap_t_prev [2];

    always @(negedge clk) begin
        if (vld8) begin
            n_vld[0]++;
            cap_data_prev[0] = cap_data[0];
            cap_data[0]      = data8;
            cap_fe[0]        = fe8;
            cap_pe[0]        = pe8;
            cap_t_prev[0]    = cap_t[0];
            cap_t[0]         = cyc;
        end
        if (vld7) begin
            n_vld[1]++;
            cap_data_prev[1] = cap_data[1];
            cap_data[1]      = data7;
            cap_fe[1]        = fe7;
            cap_pe[1]        = pe7;
            cap_t_prev[1]    = cap_t[1];
            cap_t[1]         = cyc;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    task automatic drive(input logic b, input int n);
        line = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int s, input logic [7:0] d, input logic [1:0] bad_stop,
                              input logic flip, input logic hold_low);
        int nb;
        int ns;
        logic [7:0] m;
        nb = (s == 0) ? 8 : 7;
        ns = (s == 0) ? 1 : 2;
        m  = (s == 0) ? d : (d & 8'h7F);
        cur_sel = s;
        drive(1'b0, CPB);
        for (int i = 0; i < nb; i++) drive(m[i], CPB);
        if (PE) drive((^m) ^ flip, CPB);
        for (int j = 0; j < ns; j++) drive(~bad_stop[j], CPB);
        if (!hold_low) line = 1'b1;
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [1:0] bad;
        logic       flip;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];

    int         n0, c0, s, found;
    logic [7:0] c3;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec[0] = '{0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[1] = '{0, 8'hFF, 2'b00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vec[2] = '{0, 8'h3C, 2'b01, 1'b0, 8'h3C, 1'b1, 1'b0};
        vec[3] = '{0, 8'h03, 2'b00, 1'b1, 8'h03, 1'b0, PE};
        vec[4] = '{1, 8'h41, 2'b10, 1'b0, 8'h41, 1'b1, 1'b0};
        vec[5] = '{1, 8'hC1, 2'b00, 1'b0, 8'h41, 1'b0, 1'b0};
        vec[6] = '{1, 8'h2A, 2'b01, 1'b0, 8'h2A, 1'b1, 1'b0};
        vec[7] = '{0, 8'hA5, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", vld8, 0);
        check("rst_data", data8, 0);
        check("rst_fe", fe8, 0);
        check("rst_pe", pe8, 0);
        check("rst_busy", busy8, 0);
        check("rst_busy7", busy7, 0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 8N1 0x5A with exact output latency from the falling start edge
        c0 = cyc;
        n0 = n_vld[0];
        send_frame(0, 8'h5A, 2'b00, 1'b0, 1'b0);
        drive(1'b1, CPB);
        check("5a_cnt", n_vld[0] - n0, 1);
        check("5a_data", cap_data[0], 8'h5A);
        check("5a_fe", cap_fe[0], 0);
        check("5a_pe", cap_pe[0], 0);
        check("5a_latency", cap_t[0] - c0, 155 + 16 * PE);

        // Table-driven frames
        for (int v = 0; v < NV; v++) begin
            s  = vec[v].sel;
            n0 = n_vld[s];
            send_frame(s, vec[v].data, vec[v].bad, vec[v].flip, 1'b0);
            drive(1'b1, CPB);
            check($sformatf("v%0d_cnt", v), n_vld[s] - n0, 1);
            check($sformatf("v%0d_data", v), cap_data[s], vec[v].exp_data);
            check($sformatf("v%0d_fe", v), cap_fe[s], vec[v].exp_fe);
            check($sformatf("v%0d_pe", v), cap_pe[s], vec[v].exp_pe);
            check($sformatf("v%0d_hold", v), (s == 0) ? data8 : data7, vec[v].exp_data);
        end

        // Start glitch: 5 low cycles must be rejected
        cur_sel = 0;
        n0 = n_vld[0];
        drive(1'b0, 4);
        check("glitch_busy", busy8, 1);
        drive(1'b0, 1);
        line  = 1'b1;
        found = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (!busy8) begin
                found = 1;
                break;
            end
        end
        check("glitch_idle", found, 1);
        drive(1'b1, 200);
        check("glitch_novld", n_vld[0] - n0, 0);

        // Framing error with the line held low afterwards
        n0 = n_vld[1];
        send_frame(1, 8'h41, 2'b10, 1'b0, 1'b1);
        drive(1'b0, 40);
        check("rec_cnt", n_vld[1] - n0, 1);
        check("rec_data", cap_data[1], 8'h41);
        check("rec_fe", cap_fe[1], 1);
        check("rec_busy", busy7, 1);
        line  = 1'b1;
        found = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (!busy7) begin
                found = 1;
                break;
            end
        end
        check("rec_idle", found, 1);
        drive(1'b1, CPB);

        // Reset in the middle of data bit 4
        cur_sel = 0;
        c3 = 8'hC3;
        n0 = n_vld[0];
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(c3[i], CPB);
        drive(c3[4], 8);
        rst = 1'b0;
        #1;
        check("mid_rst_vld", vld8, 0);
        check("mid_rst_data", data8, 0);
        check("mid_rst_fe", fe8, 0);
        check("mid_rst_busy", busy8, 0);
        line = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 40);
        check("mid_rst_novld", n_vld[0] - n0, 0);
        n0 = n_vld[0];
        send_frame(0, c3, 2'b00, 1'b0, 1'b0);
        drive(1'b1, CPB);
        check("c3_cnt", n_vld[0] - n0, 1);
        check("c3_data", cap_data[0], 8'hC3);
        check("c3_fe", cap_fe[0], 0);

        // Back-to-back frames with no idle gap
        n0 = n_vld[0];
        send_frame(0, 8'hFF, 2'b00, 1'b0, 1'b0);
        send_frame(0, 8'h00, 2'b00, 1'b0, 1'b0);
        drive(1'b1, CPB);
        check("b2b_cnt", n_vld[0] - n0, 2);
        check("b2b_first", cap_data_prev[0], 8'hFF);
        check("b2b_second", cap_data[0], 8'h00);
        check("b2b_gap", cap_t[0] - cap_t_prev[0], 160 + 16 * PE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receive engine: the next generation of the team's fixed 8N1 receiver. It takes the raw asynchronous serial line and synchronises it, then validates the start bit against glitches. It shifts in a configurable number of data bits LSB-first, optionally checks parity, and checks one or two stop bits. It sits between the board RX pin and the game-logic byte consumer, presenting each character as a one-cycle valid pulse with error flags.

## Interface
- `CLK_PER_BIT`, 868: clock cycles per bit (100 MHz / 115200); legal range ≥ 4.
- `DATA_BITS`, 8: data bits per frame; legal 5..8.
- `STOP_BITS`, 1: stop bits checked; legal 1 or 2.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Used only when the parity feature is compiled in.

- `clk` input 1: single system clock.
- `rst` input 1: reset, asynchronous assert, active-low.
- `din` input 1: raw serial line, asynchronous, idle high.
- `dout_vld` output 1: one-cycle pulse, character complete.
- `dout_data` output 8: received data, LSB-aligned; bits above `DATA_BITS` are 0.
- `frame_err` output 1: valid with `dout_vld`; a stop bit sampled 0.
- `parity_err` output 1: valid with `dout_vld`; parity mismatch. Tied 0 when the parity feature is compiled out.
- `busy` output 1: high in every state except IDLE.

## Operation
- `din` passes through a 2-flop synchroniser to give `din_s`. The synchroniser resets to 1.
- Counters:
  - Bit-period counter `cnt`, width $clog2(CLK_PER_BIT).
  - `HALF = CLK_PER_BIT/2`, integer division.
  - Bit index `idx`, width 3.
- States and transitions:
  - IDLE: when `din_s==0`, go to START with `cnt=0`.
  - START: `cnt` increments each cycle.
    - `din_s==1` before `cnt==HALF-1`: glitch; return to IDLE and emit no output.
    - At `cnt==HALF-1` with `din_s==0`: go to DATA with `cnt=0` and `idx=0`.
  - DATA: at `cnt==CLK_PER_BIT-1`, sample `din_s` into shift bit `idx`, clear `cnt`, increment `idx`.
    - After the `DATA_BITS`-th sample, go to PARITY if the feature is enabled, else STOP.
  - PARITY: one full bit period. At the sample point, compare against the XOR of the data, inverted when `PARITY_ODD`.
  - STOP: samples `STOP_BITS` bits the same way; any 0 sample sets `frame_err`.
    - At the last stop sample, always emit the character.
    - No error: go to IDLE.
    - Framing error: go to RECOVER.
  - RECOVER: wait for `din_s==1` (break/line-low protection), then go to IDLE.
- The data shift register clears on entry to START. Each sampled bit is ORed at position `idx`.
- Sample points sit at bit centres (±1 cycle), so back-to-back frames with no idle gap are received.

## Timing
- Reset values:
  - `dout_vld=0`, `dout_data=0`, `frame_err=0`, `parity_err=0`, `busy=0`.
  - State IDLE, all counters 0.
- Falling edge on `din` to START entry: 3 clocks (2 synchroniser cycles + 1 state register).
- Outputs are registered. `dout_vld`, `frame_err` and `parity_err` assert the cycle after the final stop-bit sample, for exactly one cycle.
- `dout_data` holds its value until the next `dout_vld`.
- Reset asserted mid-frame: immediate return to the reset values. A partial frame produces no `dout_vld`.
- A start bit arriving in the same cycle the last stop bit is sampled is seen on the following IDLE cycle. No frame is dropped.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state present, frame length is 1 + `DATA_BITS` + 1 + `STOP_BITS`, and `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: PARITY state and its logic are absent, frame length is 1 + `DATA_BITS` + `STOP_BITS`, and `parity_err` is constant 0.

## Structure
- Package `uart_pkg`:
  - State encoding localparams: IDLE, START, DATA, PARITY, STOP, RECOVER.
  - Default `CLK_PER_BIT` for 100 MHz/115200.
  - Parity-mode constants `PAR_EVEN`/`PAR_ODD`, shared with the future TX block.
- One sub-module: `sync_2ff`, a reset-to-1 double-flop synchroniser, reused by other asynchronous inputs.

## Test plan
All scenarios use `CLK_PER_BIT=16`.
- 8N1, byte 0x5A -> one `dout_vld` pulse, `dout_data=0x5A`, both error flags 0.
- `din` low for 5 cycles, then high -> no `dout_vld`; `busy` returns to 0 within 8 cycles.
- `DATA_BITS=7`, `STOP_BITS=2`, byte 0x41 with the second stop bit forced 0 -> `dout_data=0x41`, `frame_err=1`; RECOVER is held until the line goes high.
- `UART_RX_PARITY_EN` defined, `PARITY_ODD=0`, byte 0x03 sent with parity bit 1 -> `parity_err=1`, `dout_data=0x03`.
- Two back-to-back frames, 0xFF then 0x00, with zero idle gap -> two `dout_vld` pulses, 160 cycles apart, with correct data.
- `rst` pulsed low at mid-data-bit 4 -> all outputs return to 0 immediately; a following 0xC3 frame is received correctly.
